// File: rtl/traffic_clock_if.sv
// Bundles the time-of-day generator's controls and display outputs.
// The generator attaches through the master modport; the display or bench uses slave.
interface traffic_clock_if;
  logic       set_mode;
  logic       inc_hour;
  logic       inc_min;
  logic       fast;
  logic [3:0] hour_10;
  logic [3:0] hour1;
  logic [3:0] min_10;
  logic [3:0] min1;
  logic [3:0] sec_10;
  logic [3:0] sec1;
  logic       daynight;
  logic       sec_pulse;

  modport master (
    input  set_mode, inc_hour, inc_min, fast,
    output hour_10, hour1, min_10, min1, sec_10, sec1, daynight, sec_pulse
  );

  modport slave (
    output set_mode, inc_hour, inc_min, fast,
    input  hour_10, hour1, min_10, min1, sec_10, sec1, daynight, sec_pulse
  );
endinterface

// File: rtl/traffic_clock.sv
// BCD hh:mm:ss generator with a 1 s prescaler, a one-cycle second pulse,
// a set mode with button edge detection, and a fast-run mode for demos.
module traffic_clock #(
  parameter int TICK_DIV    = 1000,
  parameter int FAST_DIV    = 10,
  parameter int DAY_START   = 8,
  parameter int NIGHT_START = 23
) (
  input  logic             clk,
  input  logic             rst,
  traffic_clock_if.master  bus
);

  localparam int CW = $clog2(TICK_DIV + 1);

  logic [CW-1:0] cnt, cnt_next, term;
  logic [3:0]    h10, h1, m10, m1, s10, s1;
  logic [3:0]    h10_n, h1_n, m10_n, m1_n, s10_n, s1_n;
  logic [3:0]    h10_inc, h1_inc, m10_inc, m1_inc, s10_inc, s1_inc;
  logic          m_wrap, s_wrap;
  logic          prev_hour, prev_min, hour_rise, min_rise, tick;
  logic          pulse_q;
  logic [6:0]    hour_val;

  always_comb begin
    term      = bus.fast ? CW'(TICK_DIV / FAST_DIV - 1) : CW'(TICK_DIV - 1);
    tick      = ~bus.set_mode && (cnt >= term);
    hour_rise = bus.inc_hour & ~prev_hour;
    min_rise  = bus.inc_min & ~prev_min;

    // Single-step increments of each field; the carry chain below picks which apply.
    if (h10 == 4'd2 && h1 == 4'd3) begin
      h10_inc = 4'd0;
      h1_inc  = 4'd0;
    end else if (h1 == 4'd9) begin
      h10_inc = h10 + 4'd1;
      h1_inc  = 4'd0;
    end else begin
      h10_inc = h10;
      h1_inc  = h1 + 4'd1;
    end

    m_wrap = (m10 == 4'd5) && (m1 == 4'd9);
    if (m1 == 4'd9) begin
      m10_inc = (m10 == 4'd5) ? 4'd0 : m10 + 4'd1;
      m1_inc  = 4'd0;
    end else begin
      m10_inc = m10;
      m1_inc  = m1 + 4'd1;
    end

    s_wrap = (s10 == 4'd5) && (s1 == 4'd9);
    if (s1 == 4'd9) begin
      s10_inc = (s10 == 4'd5) ? 4'd0 : s10 + 4'd1;
      s1_inc  = 4'd0;
    end else begin
      s10_inc = s10;
      s1_inc  = s1 + 4'd1;
    end
  end

  always_comb begin
    cnt_next = cnt + CW'(1);
    h10_n    = h10;
    h1_n     = h1;
    m10_n    = m10;
    m1_n     = m1;
    s10_n    = s10;
    s1_n     = s1;

    // Set mode edits hours and minutes independently; no carry between them.
    if (bus.set_mode) begin
      cnt_next = '0;
      s10_n    = 4'd0;
      s1_n     = 4'd0;
      if (hour_rise) begin
        h10_n = h10_inc;
        h1_n  = h1_inc;
      end
      if (min_rise) begin
        m10_n = m10_inc;
        m1_n  = m1_inc;
      end
    end else if (tick) begin
      cnt_next = '0;
      s10_n    = s10_inc;
      s1_n     = s1_inc;
      if (s_wrap) begin
        m10_n = m10_inc;
        m1_n  = m1_inc;
        if (m_wrap) begin
          h10_n = h10_inc;
          h1_n  = h1_inc;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt       <= '0;
      h10       <= 4'd0;
      h1        <= 4'd0;
      m10       <= 4'd0;
      m1        <= 4'd0;
      s10       <= 4'd0;
      s1        <= 4'd0;
      prev_hour <= 1'b0;
      prev_min  <= 1'b0;
      pulse_q   <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      h10       <= h10_n;
      h1        <= h1_n;
      m10       <= m10_n;
      m1        <= m1_n;
      s10       <= s10_n;
      s1        <= s1_n;
      prev_hour <= bus.inc_hour;
      prev_min  <= bus.inc_min;
      pulse_q   <= tick;
    end
  end

  assign hour_val = {3'b000, h10} * 7'd10 + {3'b000, h1};

  assign bus.hour_10   = h10;
  assign bus.hour1     = h1;
  assign bus.min_10    = m10;
  assign bus.min1      = m1;
  assign bus.sec_10    = s10;
  assign bus.sec1      = s1;
  assign bus.sec_pulse = pulse_q;
  assign bus.daynight  = (hour_val >= 7'(NIGHT_START)) || (hour_val < 7'(DAY_START));

endmodule
